// File: rtl/add_sched.sv
// Nibble-serial add scheduler: two round-robin requesters share one 4-bit adder slice.
// Optional macro ADD_SCHED_CIN_EN adds per-requester carry-in ports.

module add_sched_nib (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  assign {c_o, s_o} = 5'(a_i) + 5'(b_i) + 5'(c_i);
endmodule

module add_sched #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_augend,
  input  logic [WIDTH-1:0] req0_addend,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_augend,
  input  logic [WIDTH-1:0] req1_addend,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carry
`ifdef ADD_SCHED_CIN_EN
  ,
  input  logic             req0_cin,
  input  logic             req1_cin
`endif
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic             last_q;
  logic             id_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] aug_q;
  logic [WIDTH-1:0] add_q;
  logic [WIDTH-1:0] sum_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_carry_q;

  logic             gnt0_c;
  logic             gnt1_c;
  logic             idle_c;
  logic             cin_c;
  logic [3:0]       slice_s_c;
  logic             slice_co_c;
  logic [WIDTH-1:0] sum_d;

  // Tie goes to the requester that was not served last
  assign gnt0_c     = req0_valid & (~req1_valid | last_q);
  assign gnt1_c     = req1_valid & ~gnt0_c;
  assign idle_c     = (state_q == IDLE) & ~reset;
  assign req0_ready = idle_c & gnt0_c;
  assign req1_ready = idle_c & gnt1_c;

`ifdef ADD_SCHED_CIN_EN
  assign cin_c = gnt1_c ? req1_cin : req0_cin;
`else
  assign cin_c = 1'b0;
`endif

  add_sched_nib u_nib (
    .a_i (aug_q[3:0]),
    .b_i (add_q[3:0]),
    .c_i (carry_q),
    .s_o (slice_s_c),
    .c_o (slice_co_c)
  );

  // Slice result enters at the MSB end; after NIB shifts the sum is aligned
  assign sum_d = (sum_q >> 4) | (WIDTH'(slice_s_c) << (WIDTH - 4));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      aug_q       <= '0;
      add_q       <= '0;
      sum_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0_ready | req1_ready) begin
            aug_q   <= gnt1_c ? req1_augend : req0_augend;
            add_q   <= gnt1_c ? req1_addend : req0_addend;
            id_q    <= gnt1_c;
            last_q  <= gnt1_c;
            carry_q <= cin_c;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          aug_q   <= aug_q >> 4;
          add_q   <= add_q >> 4;
          sum_q   <= sum_d;
          carry_q <= slice_co_c;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(NIB - 1)) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_sum_q   <= sum_d;
            rsp_carry_q <= slice_co_c;
            state_q     <= DONE;
          end
        end
        DONE: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_add_sched.sv
// Bench for add_sched: vector table plus hand sequences for latency, arbitration,
// mid-operation reset and a WIDTH=4 instance; responses checked against a queue.

module tb_add_sched;

  logic        clk;
  logic        reset;
  logic        v0, v1, r0, r1;
  logic [15:0] a0, b0, a1, b1;
  logic        rv, rid, rc;
  logic [15:0] rs;
  logic        c0, c1;

  logic        w_v0, w_v1, w_r0, w_r1;
  logic [3:0]  w_a0, w_b0, w_a1, w_b1;
  logic        w_rv, w_rid, w_rc;
  logic [3:0]  w_rs;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          id;
    logic [15:0] sum;
    bit          carry;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    bit          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    bit          carry;
  } vec_t;
  vec_t vecs[7];

  add_sched #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_ready(r0), .req0_augend(a0), .req0_addend(b0),
    .req1_valid(v1), .req1_ready(r1), .req1_augend(a1), .req1_addend(b1),
    .rsp_valid(rv), .rsp_id(rid), .rsp_sum(rs), .rsp_carry(rc)
`ifdef ADD_SCHED_CIN_EN
    , .req0_cin(c0), .req1_cin(c1)
`endif
  );

  add_sched #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(w_v0), .req0_ready(w_r0), .req0_augend(w_a0), .req0_addend(w_b0),
    .req1_valid(w_v1), .req1_ready(w_r1), .req1_augend(w_a1), .req1_addend(w_b1),
    .rsp_valid(w_rv), .rsp_id(w_rid), .rsp_sum(w_rs), .rsp_carry(w_rc)
`ifdef ADD_SCHED_CIN_EN
    , .req0_cin(c0), .req1_cin(c1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Scoreboard: every response must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && rv) begin
      if (sb_q.size() == 0) begin
        timeout("unexpected_rsp");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_id", 32'(rid), 32'(e.id));
        check("rsp_sum", 32'(rs), 32'(e.sum));
        check("rsp_carry", 32'(rc), 32'(e.carry));
      end
    end
  end

  task automatic push_exp(input bit id, input logic [15:0] s, input bit c);
    exp_t e;
    e.id = id; e.sum = s; e.carry = c;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; v0 = 0; v1 = 0; w_v0 = 0; w_v1 = 0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin done = 1; break; end
    end
    if (!done) begin
      timeout("drain");
      sb_q.delete();
    end
  endtask

  task automatic do_op(input bit id, input logic [15:0] a, input logic [15:0] b,
                       input bit cin, input logic [15:0] es, input bit ec);
    bit got = 0;
    @(posedge clk); #1;
    c0 = cin; c1 = cin;
    if (id) begin v1 = 1; a1 = a; b1 = b; v0 = 0; end
    else    begin v0 = 1; a0 = a; b0 = b; v1 = 0; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? r1 : r0) begin got = 1; break; end
    end
    if (got) push_exp(id, es, ec);
    else timeout("handshake");
    @(posedge clk); #1;
    v0 = 0; v1 = 0; c0 = 0; c1 = 0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    vecs[0] = '{0, 16'h1234, 16'h0FFF, 16'h2233, 0};
    vecs[1] = '{1, 16'hFFFF, 16'h0001, 16'h0000, 1};
    vecs[2] = '{0, 16'h8000, 16'h8000, 16'h0000, 1};
    vecs[3] = '{1, 16'hA5A5, 16'h5A5A, 16'hFFFF, 0};
    vecs[4] = '{0, 16'h0F0F, 16'h00F1, 16'h1000, 0};
    vecs[5] = '{1, 16'h7FFF, 16'h0001, 16'h8000, 0};
    vecs[6] = '{0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1};

    clk = 0; reset = 1; v0 = 0; v1 = 0; c0 = 0; c1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    w_v0 = 0; w_v1 = 0; w_a0 = 0; w_b0 = 0; w_a1 = 0; w_b1 = 0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset_rsp_valid", 32'(rv), 0);
    check("reset_rsp_sum", 32'(rs), 0);
    check("reset_rsp_carry", 32'(rc), 0);
    check("reset_rsp_id", 32'(rid), 0);
    check("idle_ready0_novalid", 32'(r0), 0);

    // Latency and busy window: handshake cycle 0, response cycle 5, next accept cycle 6
    do_reset();
    v0 = 1; a0 = 16'h1234; b0 = 16'h0FFF;
    @(negedge clk);
    check("c0_req0_ready", 32'(r0), 1);
    push_exp(0, 16'h2233, 0);
    @(posedge clk); #1;
    v0 = 0; v1 = 1; a1 = 16'hFFFF; b1 = 16'h0001;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("c%0d_rsp_valid", c), 32'(rv), 32'(c == 5));
      check($sformatf("c%0d_req1_ready", c), 32'(r1), 0);
      check($sformatf("c%0d_req0_ready", c), 32'(r0), 0);
      if (c < 5) a1 = 16'h0000;
      if (c == 4) a1 = 16'hFFFF;
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("c6_req1_ready", 32'(r1), 1);
    push_exp(1, 16'h0000, 1);
    @(posedge clk); #1;
    v1 = 0;
    drain();

    // Vector table
    foreach (vecs[i])
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, 0, vecs[i].sum, vecs[i].carry);

    // Round-robin with held valids
    do_reset();
    v0 = 1; a0 = 16'h1111; b0 = 16'h2222;
    v1 = 1; a1 = 16'h3000; b1 = 16'h4000;
    @(negedge clk);
    check("tie1_ready0", 32'(r0), 1);
    check("tie1_ready1", 32'(r1), 0);
    push_exp(0, 16'h3333, 0);
    @(posedge clk); #1;
    v0 = 0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r1) begin got = 1; break; end
    end
    if (got) push_exp(1, 16'h7000, 0);
    else timeout("rr_req1_grant");
    @(posedge clk); #1;
    v0 = 1; a0 = 16'h0005; b0 = 16'h0006;
    v1 = 1; a1 = 16'h0100; b1 = 16'h0200;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r0 || r1) begin got = 1; break; end
    end
    if (got) begin
      check("tie3_ready0", 32'(r0), 1);
      check("tie3_ready1", 32'(r1), 0);
      if (r0) push_exp(0, 16'h000B, 0);
    end else timeout("rr_tie3_grant");
    @(posedge clk); #1;
    v0 = 0; v1 = 0;
    drain();

    // Reset during RUN abandons the operation
    do_reset();
    v0 = 1; a0 = 16'h8000; b0 = 16'h8000;
    @(negedge clk);
    check("abort_accept", 32'(r0), 1);
    @(posedge clk); #1;
    v0 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1; v0 = 1; v1 = 1;
    a0 = 16'h0101; b0 = 16'h0202; a1 = 16'h0001; b1 = 16'h0001;
    @(negedge clk);
    check("rst_ready0", 32'(r0), 0);
    check("rst_ready1", 32'(r1), 0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("post_rst_rsp_valid", 32'(rv), 0);
    check("post_rst_rsp_sum", 32'(rs), 0);
    check("post_rst_rsp_carry", 32'(rc), 0);
    check("post_rst_rsp_id", 32'(rid), 0);
    check("post_rst_tie_ready0", 32'(r0), 1);
    check("post_rst_tie_ready1", 32'(r1), 0);
    if (r0) push_exp(0, 16'h0303, 0);
    @(posedge clk); #1;
    v0 = 0; v1 = 0;
    for (int c = 5; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("abort_c%0d_no_rsp", c), 32'(rv), 0);
    end
    drain();

`ifdef ADD_SCHED_CIN_EN
    do_op(0, 16'hFFFF, 16'h0000, 1, 16'h0000, 1);
    do_op(0, 16'h0001, 16'h0001, 1, 16'h0003, 0);
    do_op(1, 16'h00FF, 16'h0000, 1, 16'h0100, 0);
`endif

    // WIDTH=4 instance: response two cycles after handshake
    do_reset();
    w_v0 = 1; w_a0 = 4'h9; w_b0 = 4'h8;
    @(negedge clk);
    check("w4_ready0", 32'(w_r0), 1);
    @(posedge clk); #1;
    w_v0 = 0;
    @(negedge clk);
    check("w4_c1_rsp_valid", 32'(w_rv), 0);
    @(negedge clk);
    check("w4_c2_rsp_valid", 32'(w_rv), 1);
    check("w4_rsp_sum", 32'(w_rs), 32'h1);
    check("w4_rsp_carry", 32'(w_rc), 1);
    check("w4_rsp_id", 32'(w_rid), 0);
    @(posedge clk); #1;
    w_v1 = 1; w_a1 = 4'h7; w_b1 = 4'h8;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (w_r1) begin got = 1; break; end
    end
    if (!got) timeout("w4_req1_grant");
    @(posedge clk); #1;
    w_v1 = 0;
    @(negedge clk);
    @(negedge clk);
    check("w4b_rsp_valid", 32'(w_rv), 1);
    check("w4b_rsp_sum", 32'(w_rs), 32'hF);
    check("w4b_rsp_carry", 32'(w_rc), 0);
    check("w4b_rsp_id", 32'(w_rid), 1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
